// File: rtl/adder5_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder5_accumulator_pkg
// Description : Shared types and constants for the 5-bit accumulator slice.
// Revision    : 1.0 - initial release
// ============================================================================
package adder5_accumulator_pkg;

  // Width of the operand and running-total datapath
  localparam int DATA_W      = 5;
  // Default overflow-counter width
  localparam int OVF_W_DEF   = 4;
  // Default maximum operands per frame
  localparam int MAX_OPS_DEF = 16;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage : adder5_accumulator_pkg
`default_nettype wire

// File: rtl/adder5_accumulator_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_adder5
// Description : 5-bit ripple-carry adder built from a chain of full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder5
  import adder5_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic              carry_out,
  output logic [DATA_W-1:0] sum
);

  // Carry chain: w_carry[i] is the carry into bit i
  logic [DATA_W:0] w_carry;

  assign w_carry[0] = carry_in;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign carry_out = w_carry[DATA_W];

endmodule : ripple_adder5
`default_nettype wire

// File: rtl/adder5_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : adder5_accumulator
// Description : Frames a valid/ready stream of 5-bit operands, sums each frame
//               through ripple_adder5, counts carry-out beats and presents one
//               result per frame on a second valid/ready handshake.
//               Optional macro ADDER5_SATURATE_EN: clamp the running total to
//               31 on any carry-out instead of wrapping modulo 32.
// Revision    : 1.0 - initial release
// ============================================================================
module adder5_accumulator
  import adder5_accumulator_pkg::*;
#(
  parameter int OVF_W   = OVF_W_DEF,
  parameter int MAX_OPS = MAX_OPS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_sum,
  output logic [OVF_W-1:0]             out_ovf_cnt,
  output logic [$clog2(MAX_OPS+1)-1:0] out_count
);

  localparam int CNT_W = $clog2(MAX_OPS+1);
  localparam logic [CNT_W-1:0]  C_MAX_OPS  = CNT_W'(MAX_OPS);
  localparam logic [OVF_W-1:0]  C_OVF_FULL = {OVF_W{1'b1}};
  localparam logic [DATA_W-1:0] C_ACC_SAT  = {DATA_W{1'b1}};

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_sum_q, out_sum_d;
  logic [OVF_W-1:0]    out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;

  logic [DATA_W-1:0]   w_add_sum;
  logic                w_add_carry;
  logic [DATA_W-1:0]   w_acc_new;
  logic [OVF_W-1:0]    w_ovf_new;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_accept;
  logic                w_close;

  // The only arithmetic instance: running total plus incoming operand
  ripple_adder5 u_adder (
    .a         (acc_q),
    .b         (in_data),
    .carry_in  (1'b0),
    .carry_out (w_add_carry),
    .sum       (w_add_sum)
  );

  assign w_accept  = in_valid && in_ready_q;
  assign w_cnt_inc = cnt_q + 1'b1;
  assign w_close   = in_last || (w_cnt_inc == C_MAX_OPS);
  assign w_ovf_new = (w_add_carry && (ovf_q != C_OVF_FULL)) ? ovf_q + 1'b1 : ovf_q;

`ifdef ADDER5_SATURATE_EN
  assign w_acc_new = w_add_carry ? C_ACC_SAT : w_add_sum;
`else
  assign w_acc_new = w_add_sum;
`endif

  // Next-state, accumulation and result-capture logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (w_accept) begin
          acc_d = w_acc_new;
          ovf_d = w_ovf_new;
          cnt_d = w_cnt_inc;
          if (w_close) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = w_acc_new;
            out_ovf_d   = w_ovf_new;
            out_count_d = w_cnt_inc;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          acc_d       = '0;
          ovf_d       = '0;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered decode keeps out_ready off the in_ready path
    in_ready_d = (state_d != ST_HOLD);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_ovf_cnt = out_ovf_q;
  assign out_count   = out_count_q;

endmodule : adder5_accumulator
`default_nettype wire
